mealy_seq_detector: RTL and testbench

- Parametrised Mealy serial-pattern detector; successor of the fixed 3-state Mealy FSM.
- Scans a qualified 1-bit stream for a compile-time pattern of PAT_W bits.
- Raises Mealy output `dout` in the same cycle as the final matching bit.
- Supports overlapping or non-overlapping matching and keeps a saturating match counter. Used as a framing/sync-word detector ahead of serial receivers.

---
 rtl/mealy_seq_pkg.sv | 59 +++++
 rtl/seq_kmp_next.sv | 54 +++++
 rtl/mealy_seq_detector.sv | 80 ++++++++
 tb/tb_mealy_seq_detector.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mealy_seq_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised Mealy sequence detector.
// All functions are evaluated on parameters only; nothing here becomes runtime logic.
package mealy_seq_pkg;

    localparam logic [31:0] IDLE_ONES = '1;

    function automatic int unsigned state_w(int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

    function automatic logic pat_bit(logic [15:0] pattern, int unsigned idx);
        logic [15:0] sh;
        sh = pattern >> idx;
        return sh[0];
    endfunction

    // Longest proper border; prefix bit i is pattern[pat_w-1-i].
    function automatic int unsigned border(logic [15:0] pattern, int unsigned pat_w);
        int unsigned best;
        logic        ok;
        best = 0;
        for (int unsigned b = 1; b < 16; b++) begin
            if (b < pat_w) begin
                ok = 1'b1;
                for (int unsigned i = 0; i < 16; i++) begin
                    if (i < b && pat_bit(pattern, pat_w - 1 - i) != pat_bit(pattern, b - 1 - i))
                        ok = 1'b0;
                end
                if (ok) best = b;
            end
        end
        return best;
    endfunction

    // Matched length after appending bit b to a matched prefix of length k.
    function automatic int unsigned kmp_next(int unsigned k, logic b, logic [15:0] pattern,
                                             int unsigned pat_w);
        int unsigned best;
        int unsigned m;
        logic        ok;
        logic        sb;
        best = 0;
        for (int unsigned j = 1; j <= 16; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int unsigned i = 0; i < 16; i++) begin
                    if (i < j) begin
                        m  = k + 1 - j + i;
                        sb = (m < k) ? pat_bit(pattern, pat_w - 1 - m) : b;
                        if (sb != pat_bit(pattern, pat_w - 1 - i)) ok = 1'b0;
                    end
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_kmp_next.sv
// Combinational next-state and hit logic for the sequence detector.
// Transition tables are folded from PATTERN at elaboration.
module seq_kmp_next
    import mealy_seq_pkg::*;
#(
    parameter int unsigned       PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
    parameter bit                OVERLAP = 1'b1,
    parameter int unsigned       SW      = 3
) (
    input  logic [SW-1:0] state,
    input  logic          din_valid,
    input  logic          din,
    output logic [SW-1:0] nstate,
    output logic          hit
);

    localparam logic [15:0]   PAT16    = 16'(PATTERN);
    localparam logic [SW-1:0] ST_IDLE  = IDLE_ONES[SW-1:0];
    localparam int unsigned   RESUME   = OVERLAP ? border(PAT16, PAT_W) : 0;
    localparam logic          LAST_BIT = PATTERN[0];

    logic [SW-1:0] nxt0 [PAT_W];
    logic [SW-1:0] nxt1 [PAT_W];

    // The completing transition of the last state resumes from the border (or zero).
    for (genvar k = 0; k < int'(PAT_W); k++) begin : g_tab
        localparam bit          IS_LAST = (k == int'(PAT_W) - 1);
        localparam int unsigned N0 = (IS_LAST && LAST_BIT == 1'b0) ? RESUME
                                     : kmp_next(k, 1'b0, PAT16, PAT_W);
        localparam int unsigned N1 = (IS_LAST && LAST_BIT == 1'b1) ? RESUME
                                     : kmp_next(k, 1'b1, PAT16, PAT_W);
        assign nxt0[k] = SW'(N0);
        assign nxt1[k] = SW'(N1);
    end

    always_comb begin
        nstate = '0;
        hit    = 1'b0;
        if (state != ST_IDLE) begin
            for (int unsigned k = 0; k < PAT_W; k++) begin
                if (state == SW'(k)) begin
                    if (!din_valid) begin
                        nstate = state;
                    end else begin
                        nstate = din ? nxt1[k] : nxt0[k];
                        hit    = (k == PAT_W - 1) && (din == LAST_BIT);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy serial-pattern detector with saturating match counter.
// Define REG_OUT_EN to register dout (asserted the cycle after the final matching bit).
module mealy_seq_detector
    import mealy_seq_pkg::*;
#(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         din_valid,
    input  logic                         din,
    output logic                         dout,
    output logic [CNT_W-1:0]             match_cnt,
    output logic [$clog2(PAT_W+1)-1:0]   state_o
);

    localparam int unsigned   SW      = state_w(PAT_W);
    localparam logic [SW-1:0] ST_IDLE = IDLE_ONES[SW-1:0];

    logic [SW-1:0]    state_q, state_d, nstate;
    logic             hit;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    seq_kmp_next #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP),
        .SW      (SW)
    ) u_next (
        .state     (state_q),
        .din_valid (din_valid),
        .din       (din),
        .nstate    (nstate),
        .hit       (hit)
    );

    always_comb begin
        state_d = clr ? ST_IDLE : nstate;
        cnt_d   = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (hit && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef REG_OUT_EN
    logic dout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= 1'b0;
        end else begin
            dout_q <= clr ? 1'b0 : hit;
        end
    end

    assign dout = dout_q;
`else
    assign dout = hit;
`endif

    assign match_cnt = cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Self-checking bench: three detector instances (overlap, non-overlap, 2-bit counter)
// compared against a shift-register reference model through an expected-value queue.
module tb_mealy_seq_detector;

    localparam logic [3:0] PAT = 4'b1011;

    logic       clk = 1'b0;
    logic       rst, clr, din_valid, din;
    logic       dout_a, dout_b, dout_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic [2:0] st_a, st_b, st_c;

    always #5 clk = ~clk;

    mealy_seq_detector #(.PAT_W(4), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
        .dout(dout_a), .match_cnt(cnt_a), .state_o(st_a));
    mealy_seq_detector #(.PAT_W(4), .PATTERN(PAT), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
        .dout(dout_b), .match_cnt(cnt_b), .state_o(st_b));
    mealy_seq_detector #(.PAT_W(4), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
        .dout(dout_c), .match_cnt(cnt_c), .state_o(st_c));

    typedef struct packed {
        logic [2:0] dout;
        logic [7:0] ca;
        logic [7:0] cb;
        logic [1:0] cc;
    } smp_t;

    smp_t exp_q[$];
    smp_t obs_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: history shift register plus count of bits accepted since arm/restart.
    bit         m_armed [3];
    logic [3:0] m_hist  [3];
    int         m_since [3];
    int         m_cnt   [3];
    int         m_max   [3] = '{255, 255, 3};
    bit         m_ovl   [3] = '{1'b1, 1'b0, 1'b1};
    logic [2:0] m_hit_prev;

    function automatic bit model_hit(int i, logic v, logic d);
        logic [3:0] w;
        w = {m_hist[i][2:0], d};
        return m_armed[i] && v && (m_since[i] >= 3) && (w == PAT);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_armed[i] = 1'b0;
            m_hist[i]  = '0;
            m_since[i] = 0;
            m_cnt[i]   = 0;
        end
        m_hit_prev = '0;
    endtask

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic drive(input logic v, input logic d, input logic c);
        smp_t       e, o;
        logic [2:0] h;
        din_valid = v;
        din       = d;
        clr       = c;
        for (int i = 0; i < 3; i++) h[i] = model_hit(i, v, d);
`ifdef REG_OUT_EN
        e.dout = m_hit_prev;
`else
        e.dout = h;
`endif
        @(negedge clk);
        o.dout = {dout_c, dout_b, dout_a};
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (c) begin
                m_armed[i] = 1'b0;
                m_since[i] = 0;
                m_cnt[i]   = 0;
            end else if (!m_armed[i]) begin
                m_armed[i] = 1'b1;
                m_since[i] = 0;
            end else if (v) begin
                m_hist[i] = {m_hist[i][2:0], d};
                m_since[i]++;
                if (h[i]) begin
                    if (m_cnt[i] < m_max[i]) m_cnt[i]++;
                    if (!m_ovl[i]) m_since[i] = 0;
                end
            end
        end
        m_hit_prev = c ? 3'b000 : h;
        #1;
        e.ca = 8'(m_cnt[0]);
        e.cb = 8'(m_cnt[1]);
        e.cc = 2'(m_cnt[2]);
        o.ca = cnt_a;
        o.cb = cnt_b;
        o.cc = cnt_c;
        exp_q.push_back(e);
        obs_q.push_back(o);
        clr = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        clr       = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        smp_t e, o;
        model_reset();
        rst       = 1'b1;
        din_valid = 1'b1;
        din       = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({st_a, st_b, st_c} !== 9'h1ff) $display("FAIL reset_state got %h want 1ff", {st_a, st_b, st_c});
        else n_pass++;
        n_checks++;
        if ({dout_a, dout_b, dout_c} !== 3'b000) $display("FAIL reset_dout got %b want 000", {dout_a, dout_b, dout_c});
        else n_pass++;
        n_checks++;
        if ({cnt_a, cnt_b, cnt_c} !== 18'h0) $display("FAIL reset_cnt got %h want 0", {cnt_a, cnt_b, cnt_c});
        else n_pass++;
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (st_a !== 3'd0) $display("FAIL arm_state got %0d want 0", st_a);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL reset_sb got %h want %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_single_match();
        smp_t       e, o;
        logic [3:0] bits;
        bits = 4'b1011;
        do_reset();
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) drive(1'b1, bits[i], 1'b0);
        n_checks++;
        if (cnt_a !== 8'd1) $display("FAIL single_cnt got %0d want 1", cnt_a);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.dout !== e.dout) $display("FAIL single_dout got %b want %b", o.dout, e.dout);
            else n_pass++;
            n_checks++;
            if ({o.ca, o.cb, o.cc} !== {e.ca, e.cb, e.cc}) $display("FAIL single_cnt_sb got %h want %h", {o.ca, o.cb, o.cc}, {e.ca, e.cb, e.cc});
            else n_pass++;
        end
    endtask

    task automatic test_overlap();
        smp_t       e, o;
        logic [6:0] bits;
        bits = 7'b1011011;
        do_reset();
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 6; i >= 0; i--) drive(1'b1, bits[i], 1'b0);
        n_checks++;
        if (cnt_a !== 8'd2 || cnt_b !== 8'd1) $display("FAIL overlap_cnt got %0d/%0d want 2/1", cnt_a, cnt_b);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL overlap_sb got %h want %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_fallback();
        smp_t       e, o;
        logic [5:0] bits;
        bits = 6'b101011;
        do_reset();
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 5; i >= 0; i--) begin
            drive(1'b1, bits[i], 1'b0);
            if (i == 2) begin
                n_checks++;
                if (st_a !== 3'd2) $display("FAIL fallback_state got %0d want 2", st_a);
                else n_pass++;
            end
        end
        n_checks++;
        if (cnt_a !== 8'd1) $display("FAIL fallback_cnt got %0d want 1", cnt_a);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL fallback_sb got %h want %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_gaps();
        smp_t       e, o;
        logic [3:0] bits;
        logic [2:0] exp_st [4] = '{3'd1, 3'd2, 3'd3, 3'd1};
        bits = 4'b1011;
        do_reset();
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, bits[3-i], 1'b0);
            drive(1'b0, ~bits[3-i], 1'b0);
            n_checks++;
            if (st_a !== exp_st[i]) $display("FAIL gap_state%0d got %0d want %0d", i, st_a, exp_st[i]);
            else n_pass++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL gap_sb got %h want %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        smp_t e, o;
        do_reset();
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        din_valid = 1'b1;
        din       = 1'b1;
        #1;
`ifndef REG_OUT_EN
        n_checks++;
        if (dout_a !== 1'b1) $display("FAIL premid_dout got %b want 1", dout_a);
        else n_pass++;
`endif
        rst = 1'b1;
        #1;
        n_checks++;
        if (st_a !== 3'd7 || dout_a !== 1'b0) $display("FAIL midrst got st=%0d dout=%b want st=7 dout=0", st_a, dout_a);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (cnt_a !== 8'd0) $display("FAIL midrst_cnt got %0d want 0", cnt_a);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL midrst_sb got %h want %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        smp_t       e, o;
        logic [3:0] bits;
        bits = 4'b1011;
        do_reset();
        drive(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++)
            for (int i = 3; i >= 0; i--) drive(1'b1, bits[i], 1'b0);
        n_checks++;
        if (cnt_c !== 2'd3 || cnt_a !== 8'd5) $display("FAIL sat_cnt got %0d/%0d want 3/5", cnt_c, cnt_a);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL sat_sb got %h want %h", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_clr_match();
        smp_t       e, o;
        logic [6:0] bits;
        bits = 7'b1011011;
        do_reset();
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 6; i >= 1; i--) drive(1'b1, bits[i], 1'b0);
        drive(1'b1, bits[0], 1'b1);
        n_checks++;
        if (cnt_a !== 8'd0 || st_a !== 3'd7) $display("FAIL clr_match got cnt=%0d st=%0d want cnt=0 st=7", cnt_a, st_a);
        else n_pass++;
        drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (st_a !== 3'd0) $display("FAIL clr_rearm got %0d want 0", st_a);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL clr_sb got %h want %h", o, e);
            else n_pass++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;
        test_reset();
        test_single_match();
        test_overlap();
        test_fallback();
        test_gaps();
        test_mid_reset();
        test_saturate();
        test_clr_match();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
